ga_sync_int: RTL and testbench



---
 rtl/ga_sync_pkg.sv | 19 +
 rtl/ga_sync_shaper.sv | 85 ++++++++
 rtl/ga_sync_int.sv | 121 ++++++++++++
 tb/tb_ga_sync_int.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ga_sync_pkg.sv
// Shared types and default timing constants for the Gate Array sync/interrupt block.
package ga_sync_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_ACTIVE = 2'd2
  } shaper_state_e;

  localparam int HS_DELAY   = 2;
  localparam int HS_WIDTH   = 4;
  localparam int VS_DELAY   = 2;
  localparam int VS_WIDTH   = 4;
  localparam int INT_LINES  = 52;
  localparam int INT_CNT_W  = 6;
  // A VSYNC resync only raises INT if at least this many lines have elapsed.
  localparam int INT_RESYNC_MIN = 32;

endpackage

// File: rtl/ga_sync_shaper.sv
// Delays a sync pulse by DELAY ticks and limits its width to WIDTH ticks.
// state     | meaning
// ST_IDLE   | waiting for a start edge, output low
// ST_DELAY  | counting delay ticks, output low
// ST_ACTIVE | output high, counting width ticks
module ga_sync_shaper
  import ga_sync_pkg::*;
#(
  parameter int DELAY = 2,
  parameter int WIDTH = 4
) (
  input  logic CLOCK,
  input  logic RESET,
  input  logic TICK,
  input  logic START,
  input  logic SRC,
  output logic OUT,
  output logic AT_DELAY
);

  localparam int CMAX = (DELAY > WIDTH) ? DELAY : WIDTH;
  localparam int CW   = $clog2(CMAX + 1);

  shaper_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          out_q, out_d;

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      out_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
    AT_DELAY = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (START) begin
          state_d = ST_DELAY;
          cnt_d   = '0;
        end
      end
      ST_DELAY: begin
        if (TICK) begin
          if (!SRC) begin
            state_d = ST_IDLE;
          end else if (cnt_q == CW'(DELAY - 1)) begin
            state_d  = ST_ACTIVE;
            cnt_d    = '0;
            out_d    = 1'b1;
            AT_DELAY = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      ST_ACTIVE: begin
        if (TICK) begin
          if (!SRC || (cnt_q == CW'(WIDTH - 1))) begin
            state_d = ST_IDLE;
            out_d   = 1'b0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        out_d   = 1'b0;
      end
    endcase
  end

  assign OUT = out_q;

endmodule

// File: rtl/ga_sync_int.sv
// Gate Array sync shaping, 52-line raster interrupt counter and HSYNC-aligned mode latch.
// Receives CRTC HSYNC/VSYNC and drives monitor sync plus the Z80 interrupt request.
module ga_sync_int #(
  parameter int HS_DELAY  = ga_sync_pkg::HS_DELAY,
  parameter int HS_WIDTH  = ga_sync_pkg::HS_WIDTH,
  parameter int VS_DELAY  = ga_sync_pkg::VS_DELAY,
  parameter int VS_WIDTH  = ga_sync_pkg::VS_WIDTH,
  parameter int INT_LINES = ga_sync_pkg::INT_LINES
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       CLKEN,
  input  logic       HSYNC_IN,
  input  logic       VSYNC_IN,
  input  logic       INT_ACK,
  input  logic       CNT_CLR,
  input  logic       MODE_WE,
  input  logic [1:0] MODE_IN,
  output logic       HSYNC_OUT,
  output logic       VSYNC_OUT,
  output logic       INT,
  output logic [5:0] INT_CNT,
  output logic [1:0] MODE
);
  import ga_sync_pkg::*;

  localparam logic [INT_CNT_W-1:0] CNT_LAST   = INT_CNT_W'(INT_LINES - 1);
  localparam logic [INT_CNT_W-1:0] CNT_RESYNC = INT_CNT_W'(INT_RESYNC_MIN);

  logic                 h_prev_q, v_prev_q;
  logic                 primed_q;
  logic [1:0]           pend_q, pend_d;
  logic [1:0]           mode_q, mode_d;
  logic [INT_CNT_W-1:0] cnt_q, cnt_d;
  logic                 int_q, int_d;
  logic                 hs_rise, hs_fall, vs_rise;
  logic                 h_at_delay, v_at_delay;

  // primed_q blocks rise detection until the inputs have been sampled once after
  // reset, so a sync already high at release is not mistaken for a fresh edge.
  assign hs_rise = CLKEN &  HSYNC_IN & ~h_prev_q & primed_q;
  assign hs_fall = CLKEN & ~HSYNC_IN &  h_prev_q;
  assign vs_rise = CLKEN &  VSYNC_IN & ~v_prev_q & primed_q;

  ga_sync_shaper #(.DELAY(HS_DELAY), .WIDTH(HS_WIDTH)) u_h_shaper (
    .CLOCK    (CLOCK),
    .RESET    (RESET),
    .TICK     (CLKEN),
    .START    (hs_rise),
    .SRC      (HSYNC_IN),
    .OUT      (HSYNC_OUT),
    .AT_DELAY (h_at_delay)
  );

  ga_sync_shaper #(.DELAY(VS_DELAY), .WIDTH(VS_WIDTH)) u_v_shaper (
    .CLOCK    (CLOCK),
    .RESET    (RESET),
    .TICK     (hs_fall),
    .START    (vs_rise),
    .SRC      (VSYNC_IN),
    .OUT      (VSYNC_OUT),
    .AT_DELAY (v_at_delay)
  );

  always_comb begin
    pend_d = MODE_WE ? MODE_IN : pend_q;
    mode_d = hs_rise ? pend_d : mode_q;
  end

  always_comb begin
    cnt_d = cnt_q;
    int_d = int_q;
    if (CNT_CLR) begin
      cnt_d = '0;
      int_d = 1'b0;
    end else begin
      if (INT_ACK) begin
        int_d                = 1'b0;
        cnt_d[INT_CNT_W-1]   = 1'b0;
      end
      if (hs_fall) begin
        if (v_at_delay) begin
          if (cnt_q >= CNT_RESYNC) int_d = 1'b1;
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          int_d = 1'b1;
        end else begin
          cnt_d = cnt_d + INT_CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      h_prev_q <= 1'b0;
      v_prev_q <= 1'b0;
      primed_q <= 1'b0;
      pend_q   <= '0;
      mode_q   <= '0;
      cnt_q    <= '0;
      int_q    <= 1'b0;
    end else begin
      if (CLKEN) begin
        h_prev_q <= HSYNC_IN;
        v_prev_q <= VSYNC_IN;
        primed_q <= 1'b1;
      end
      pend_q <= pend_d;
      mode_q <= mode_d;
      cnt_q  <= cnt_d;
      int_q  <= int_d;
    end
  end

  assign INT     = int_q;
  assign INT_CNT = cnt_q;
  assign MODE    = mode_q;

endmodule

// File: tb/tb_ga_sync_int.sv
// Directed plus randomized bench for ga_sync_int against a tick-age reference model.
module tb_ga_sync_int;

  localparam int HD = 2, HW = 4, VD = 2, VW = 4, NL = 52;

  logic       CLOCK = 1'b0;
  logic       RESET, CLKEN, HSYNC_IN, VSYNC_IN, INT_ACK, CNT_CLR, MODE_WE;
  logic [1:0] MODE_IN;
  logic       HSYNC_OUT, VSYNC_OUT, INT;
  logic [5:0] INT_CNT;
  logic [1:0] MODE;

  ga_sync_int dut (
    .CLOCK(CLOCK), .RESET(RESET), .CLKEN(CLKEN), .HSYNC_IN(HSYNC_IN), .VSYNC_IN(VSYNC_IN),
    .INT_ACK(INT_ACK), .CNT_CLR(CNT_CLR), .MODE_WE(MODE_WE), .MODE_IN(MODE_IN),
    .HSYNC_OUT(HSYNC_OUT), .VSYNC_OUT(VSYNC_OUT), .INT(INT), .INT_CNT(INT_CNT), .MODE(MODE)
  );

  always #5 CLOCK = ~CLOCK;

  int errors = 0;
  int checks = 0;
  bit rnd_on = 1'b0;

  // Reference model: each shaper is a "ticks since start" age (-1 = idle).
  bit       m_hprev, m_vprev, m_primed, m_hout, m_vout, m_int;
  int       h_age, v_age, m_cnt;
  logic [1:0] m_pend, m_mode;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic shape(inout int age, inout bit o, input bit tick, input bit src,
                       input bit start, input int d, input int w);
    if (age >= 0) begin
      if (tick) begin
        if (!src) begin
          age = -1;
          o   = 1'b0;
        end else begin
          age++;
          o = (age >= d) && (age < d + w);
          if (age >= d + w) age = -1;
        end
      end
    end else if (start) begin
      age = 0;
    end
  endtask

  task automatic model_step();
    bit hr, hf, vr, v_at, i;
    int c;
    logic [1:0] np;
    if (RESET) begin
      m_hprev = 0; m_vprev = 0; m_primed = 0; m_hout = 0; m_vout = 0; m_int = 0;
      h_age = -1; v_age = -1; m_cnt = 0; m_pend = 2'd0; m_mode = 2'd0;
    end else begin
      hr   = CLKEN && HSYNC_IN && !m_hprev && m_primed;
      hf   = CLKEN && !HSYNC_IN && m_hprev;
      vr   = CLKEN && VSYNC_IN && !m_vprev && m_primed;
      v_at = (v_age >= 0) && hf && VSYNC_IN && (v_age + 1 == VD);
      shape(h_age, m_hout, CLKEN, HSYNC_IN, hr, HD, HW);
      shape(v_age, m_vout, hf, VSYNC_IN, vr, VD, VW);
      if (CNT_CLR) begin
        m_cnt = 0;
        m_int = 0;
      end else begin
        c = m_cnt;
        i = m_int;
        if (INT_ACK) begin
          i = 0;
          c = c % 32;
        end
        if (hf) begin
          if (v_at) begin
            if (m_cnt >= 32) i = 1;
            c = 0;
          end else if (m_cnt == NL - 1) begin
            c = 0;
            i = 1;
          end else begin
            c = c + 1;
          end
        end
        m_cnt = c;
        m_int = i;
      end
      np = MODE_WE ? MODE_IN : m_pend;
      if (hr) m_mode = np;
      m_pend = np;
      if (CLKEN) begin
        m_hprev  = HSYNC_IN;
        m_vprev  = VSYNC_IN;
        m_primed = 1;
      end
    end
  endtask

  task automatic clk1();
    if (rnd_on) begin
      if ($urandom_range(0, 39) == 0)  INT_ACK = 1'b1;
      if ($urandom_range(0, 399) == 0) CNT_CLR = 1'b1;
      if ($urandom_range(0, 29) == 0) begin
        MODE_WE = 1'b1;
        MODE_IN = 2'($urandom_range(0, 3));
      end
    end
    @(posedge CLOCK);
    model_step();
    #1;
    chk("hsync_out", int'(HSYNC_OUT), int'(m_hout));
    chk("vsync_out", int'(VSYNC_OUT), int'(m_vout));
    chk("int",       int'(INT),       int'(m_int));
    chk("int_cnt",   int'(INT_CNT),   m_cnt);
    chk("mode",      int'(MODE),      int'(m_mode));
    CLKEN = 0; INT_ACK = 0; CNT_CLR = 0; MODE_WE = 0;
  endtask

  task automatic chr(input bit hs, input bit vs);
    HSYNC_IN = hs;
    VSYNC_IN = vs;
    CLKEN    = 1'b1;
    clk1();
    clk1();
  endtask

  task automatic line(input int hw, input bit vs, input bit clr_f, input bit ack_f);
    for (int i = 0; i < 20; i++) begin
      if (i == hw) begin
        if (clr_f) CNT_CLR = 1'b1;
        if (ack_f) INT_ACK = 1'b1;
      end
      chr(i < hw, vs);
    end
  endtask

  task automatic lines(input int n);
    for (int i = 0; i < n; i++) line(4, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic clear_cnt();
    CNT_CLR = 1'b1;
    clk1();
  endtask

  initial begin
    int first, n;
    bit vs_lvl;
    RESET = 1; CLKEN = 0; HSYNC_IN = 0; VSYNC_IN = 0;
    INT_ACK = 0; CNT_CLR = 0; MODE_WE = 0; MODE_IN = 2'd0;
    clk1();
    clk1();
    RESET = 0;
    chk("rst_hsync", int'(HSYNC_OUT), 0);
    chk("rst_vsync", int'(VSYNC_OUT), 0);
    chk("rst_int",   int'(INT), 0);
    chk("rst_cnt",   int'(INT_CNT), 0);
    chk("rst_mode",  int'(MODE), 0);
    chr(0, 0);
    chr(0, 0);

    // 52 lines without VSYNC raise INT and wrap the counter
    lines(51);
    chk("cnt_51", int'(INT_CNT), 51);
    chk("int_before_52", int'(INT), 0);
    lines(1);
    chk("int_at_52", int'(INT), 1);
    chk("cnt_wrap", int'(INT_CNT), 0);
    lines(8);
    chk("cnt_60", int'(INT_CNT), 8);
    lines(2);
    INT_ACK = 1'b1;
    clk1();
    chk("ack_int", int'(INT), 0);
    chk("ack_cnt10", int'(INT_CNT), 10);

    // HSYNC shaping: long pulse limited to width, short pulse cut by source
    first = -1; n = 0;
    for (int i = 0; i < 20; i++) begin
      chr(i < 14, 0);
      if (HSYNC_OUT) begin
        if (first < 0) first = i;
        n++;
      end
    end
    chk("hs14_first", first, HD);
    chk("hs14_width", n, HW);
    first = -1; n = 0;
    for (int i = 0; i < 20; i++) begin
      chr(i < 4, 0);
      if (HSYNC_OUT) begin
        if (first < 0) first = i;
        n++;
      end
    end
    chk("hs4_first", first, HD);
    chk("hs4_width", n, 2);

    // VSYNC resync with INT_CNT = 40
    clear_cnt();
    lines(40);
    chk("cnt_40", int'(INT_CNT), 40);
    line(4, 1, 0, 0);
    chk("vs_first_fall_cnt", int'(INT_CNT), 41);
    chk("vs_first_fall_out", int'(VSYNC_OUT), 0);
    line(4, 1, 0, 0);
    chk("resync40_cnt", int'(INT_CNT), 0);
    chk("resync40_int", int'(INT), 1);
    n = int'(VSYNC_OUT);
    for (int i = 0; i < 6; i++) begin
      line(4, 1, 0, 0);
      n += int'(VSYNC_OUT);
    end
    chk("vs_width", n, VW);
    line(4, 0, 0, 0);

    // VSYNC resync with INT_CNT = 20 leaves INT low
    clear_cnt();
    lines(20);
    line(4, 1, 0, 0);
    line(4, 1, 0, 0);
    chk("resync20_cnt", int'(INT_CNT), 0);
    chk("resync20_int", int'(INT), 0);
    for (int i = 0; i < 5; i++) line(4, 1, 0, 0);
    line(4, 0, 0, 0);

    // INT_ACK clears bit 5 only
    clear_cnt();
    lines(45);
    INT_ACK = 1'b1;
    clk1();
    chk("ack45_cnt", int'(INT_CNT), 13);
    chk("ack45_int", int'(INT), 0);

    // CNT_CLR beats the wrapping hs_fall
    clear_cnt();
    lines(51);
    line(4, 0, 1, 0);
    chk("clr_wrap_int", int'(INT), 0);
    chk("clr_wrap_cnt", int'(INT_CNT), 0);

    // INT_ACK with the wrap leaves INT set
    clear_cnt();
    lines(51);
    line(4, 0, 0, 1);
    chk("ack_wrap_int", int'(INT), 1);
    chk("ack_wrap_cnt", int'(INT_CNT), 0);

    // Mode latch
    chr(0, 0);
    MODE_IN = 2'd2;
    MODE_WE = 1'b1;
    clk1();
    chk("mode_pending", int'(MODE), 0);
    chr(0, 0);
    chr(0, 0);
    chk("mode_still_old", int'(MODE), 0);
    chr(1, 0);
    chk("mode_at_rise", int'(MODE), 2);
    for (int i = 0; i < 10; i++) chr(i < 3, 0);
    MODE_IN = 2'd1;
    MODE_WE = 1'b1;
    chr(1, 0);
    chk("mode_we_at_rise", int'(MODE), 1);
    for (int i = 0; i < 10; i++) chr(i < 3, 0);

    // Reset mid-frame with all outputs high
    clear_cnt();
    lines(40);
    line(4, 1, 0, 0);
    line(4, 1, 0, 0);
    chr(1, 1);
    chr(1, 1);
    chr(1, 1);
    chk("pre_rst_hsync", int'(HSYNC_OUT), 1);
    chk("pre_rst_vsync", int'(VSYNC_OUT), 1);
    chk("pre_rst_int",   int'(INT), 1);
    RESET = 1'b1;
    clk1();
    RESET = 1'b0;
    chk("rst_mid_hsync", int'(HSYNC_OUT), 0);
    chk("rst_mid_vsync", int'(VSYNC_OUT), 0);
    chk("rst_mid_int",   int'(INT), 0);
    chk("rst_mid_cnt",   int'(INT_CNT), 0);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      chr(1, 1);
      n += int'(HSYNC_OUT);
    end
    chk("no_hsync_after_rst", n, 0);
    chr(0, 0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      chr(i < 4, 0);
      n += int'(HSYNC_OUT);
    end
    chk("hsync_resumes", n, 2);

    // Randomized frames
    rnd_on = 1'b1;
    vs_lvl = 1'b0;
    for (int l = 0; l < 150; l++) begin
      if ($urandom_range(0, 9) == 0) vs_lvl = ~vs_lvl;
      line(int'($urandom_range(1, 14)), vs_lvl, 0, 0);
    end
    rnd_on = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
